// File: rtl/psg_mix_pkg.sv
// Shared types and constants for the PSG stereo mixer slice.
// Optional sigma-delta DAC output is enabled by the PSG_SIGMA_DELTA_EN macro.
package psg_mix_pkg;

    localparam int unsigned MIX_W = 10;
    localparam int unsigned CH_W  = 8;

    localparam logic [CH_W-1:0] BEEP_LEVEL = 8'd255;

    localparam logic [1:0] MODE_MONO = 2'b00;
    localparam logic [1:0] MODE_ABC  = 2'b01;
    localparam logic [1:0] MODE_ACB  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_ADD0,
        ST_ADD1,
        ST_ADD2,
        ST_ADD3,
        ST_DONE
    } mix_state_e;

    typedef struct packed {
        logic [CH_W-1:0] a;
        logic [CH_W-1:0] b;
        logic [CH_W-1:0] c;
        logic            beep;
        logic [1:0]      mode;
        logic            mute;
    } mix_snap_t;

    // Term idx (0..3) of the left or right mix for the captured snapshot.
    function automatic logic [CH_W-1:0] mix_term(input mix_snap_t s,
                                                 input logic [1:0] idx,
                                                 input logic right);
        logic [CH_W-1:0] bp;
        logic [CH_W-1:0] t;
        bp = s.beep ? BEEP_LEVEL : 8'd0;
        t  = bp;
        case (s.mode)
            MODE_ABC: begin
                if (idx != 2'd3) t = (idx == 2'd2) ? s.b : (right ? s.c : s.a);
            end
            MODE_ACB: begin
                if (idx != 2'd3) t = (idx == 2'd2) ? s.c : (right ? s.b : s.a);
            end
            default: begin
                case (idx)
                    2'd0:    t = s.a;
                    2'd1:    t = s.b;
                    2'd2:    t = s.c;
                    default: t = bp;
                endcase
            end
        endcase
        return t;
    endfunction

endpackage

// File: rtl/psg_sigma_delta.sv
// First-order sigma-delta modulator: ones-density of dac_o is level_i / 2^MIX_W.
module psg_sigma_delta
    import psg_mix_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [MIX_W-1:0] level_i,
    output logic             dac_o
);

    localparam int unsigned ACC_W = MIX_W + 1;

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;

    // Carry out of the previous add is dropped from the running sum and becomes the bit.
    always_comb begin
        acc_d = ACC_W'(acc_q[MIX_W-1:0]) + ACC_W'(level_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
    end

    assign dac_o = acc_q[MIX_W];

endmodule

// File: rtl/psg_stereo_mixer.sv
// Sequential stereo mixer for three PSG channels plus beeper, one term per clock.
// Define PSG_SIGMA_DELTA_EN to build the per-side sigma-delta DAC outputs.
module psg_stereo_mixer
    import psg_mix_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce_sample_i,
    input  logic [7:0]       channel_a_i,
    input  logic [7:0]       channel_b_i,
    input  logic [7:0]       channel_c_i,
    input  logic             beeper_i,
    input  logic [1:0]       stereo_mode_i,
    input  logic             mute_i,
    output logic [MIX_W-1:0] audio_l_o,
    output logic [MIX_W-1:0] audio_r_o,
    output logic             sample_valid_o,
    output logic             overrun_o,
    output logic             dac_l_o,
    output logic             dac_r_o
);

    mix_state_e       state_q, state_d;
    mix_snap_t        snap_q, snap_d;
    logic [MIX_W-1:0] acc_l_q, acc_l_d;
    logic [MIX_W-1:0] acc_r_q, acc_r_d;
    logic [MIX_W-1:0] audio_l_q, audio_l_d;
    logic [MIX_W-1:0] audio_r_q, audio_r_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;

    logic [1:0]       term_idx;
    logic [CH_W-1:0]  term_l;
    logic [CH_W-1:0]  term_r;

    always_comb begin
        case (state_q)
            ST_ADD1: term_idx = 2'd1;
            ST_ADD2: term_idx = 2'd2;
            ST_ADD3: term_idx = 2'd3;
            default: term_idx = 2'd0;
        endcase
    end

    assign term_l = mix_term(snap_q, term_idx, 1'b0);
    assign term_r = mix_term(snap_q, term_idx, 1'b1);

    // Next-state and datapath; any strobe outside IDLE only raises the sticky overrun.
    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        acc_l_d   = acc_l_q;
        acc_r_d   = acc_r_q;
        audio_l_d = audio_l_q;
        audio_r_d = audio_r_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q;

        if (ce_sample_i && (state_q != ST_IDLE)) overrun_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (ce_sample_i) begin
                    snap_d.a    = channel_a_i;
                    snap_d.b    = channel_b_i;
                    snap_d.c    = channel_c_i;
                    snap_d.beep = beeper_i;
                    snap_d.mode = stereo_mode_i;
                    snap_d.mute = mute_i;
                    state_d     = ST_LATCH;
                end
            end
            ST_LATCH: begin
                acc_l_d = '0;
                acc_r_d = '0;
                state_d = ST_ADD0;
            end
            ST_ADD0, ST_ADD1, ST_ADD2, ST_ADD3: begin
                acc_l_d = acc_l_q + MIX_W'(term_l);
                acc_r_d = acc_r_q + MIX_W'(term_r);
                case (state_q)
                    ST_ADD0: state_d = ST_ADD1;
                    ST_ADD1: state_d = ST_ADD2;
                    ST_ADD2: state_d = ST_ADD3;
                    default: state_d = ST_DONE;
                endcase
            end
            ST_DONE: begin
                audio_l_d = snap_q.mute ? '0 : acc_l_q;
                audio_r_d = snap_q.mute ? '0 : acc_r_q;
                valid_d   = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            snap_q    <= '0;
            acc_l_q   <= '0;
            acc_r_q   <= '0;
            audio_l_q <= '0;
            audio_r_q <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            acc_l_q   <= acc_l_d;
            acc_r_q   <= acc_r_d;
            audio_l_q <= audio_l_d;
            audio_r_q <= audio_r_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign audio_l_o      = audio_l_q;
    assign audio_r_o      = audio_r_q;
    assign sample_valid_o = valid_q;
    assign overrun_o      = overrun_q;

`ifdef PSG_SIGMA_DELTA_EN
    psg_sigma_delta u_sd_l (
        .clk     (clk),
        .rst_n   (rst_n),
        .level_i (audio_l_q),
        .dac_o   (dac_l_o)
    );

    psg_sigma_delta u_sd_r (
        .clk     (clk),
        .rst_n   (rst_n),
        .level_i (audio_r_q),
        .dac_o   (dac_r_o)
    );
`else
    assign dac_l_o = 1'b0;
    assign dac_r_o = 1'b0;
`endif

endmodule

// File: tb/tb_psg_stereo_mixer.sv
// Self-checking bench for psg_stereo_mixer against a sum-based stereo mix model.
module tb_psg_stereo_mixer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ce;
    logic [7:0] ch_a, ch_b, ch_c;
    logic       beep;
    logic [1:0] mode;
    logic       mute;
    logic [9:0] audio_l, audio_r;
    logic       sv, ovr, dac_l, dac_r;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    psg_stereo_mixer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ce_sample_i    (ce),
        .channel_a_i    (ch_a),
        .channel_b_i    (ch_b),
        .channel_c_i    (ch_c),
        .beeper_i       (beep),
        .stereo_mode_i  (mode),
        .mute_i         (mute),
        .audio_l_o      (audio_l),
        .audio_r_o      (audio_r),
        .sample_valid_o (sv),
        .overrun_o      (ovr),
        .dac_l_o        (dac_l),
        .dac_r_o        (dac_r)
    );

    // Expected mix: ABC puts A twice left, C twice right; ACB puts A left, B right; else mono.
    function automatic int ref_side(input logic [1:0] m, input int ca, input int cb,
                                    input int cc, input logic bp, input logic right);
        int beepv;
        beepv = bp ? 255 : 0;
        case (m)
            2'b01:   return right ? (2*cc + cb + beepv) : (2*ca + cb + beepv);
            2'b10:   return right ? (2*cb + cc + beepv) : (2*ca + cc + beepv);
            default: return ca + cb + cc + beepv;
        endcase
    endfunction

    task automatic set_inputs(input logic [1:0] m, input int ca, input int cb, input int cc,
                              input logic bp, input logic mt);
        mode = m;
        ch_a = 8'(ca);
        ch_b = 8'(cb);
        ch_c = 8'(cc);
        beep = bp;
        mute = mt;
    endtask

    task automatic scramble_inputs();
        ch_a = 8'($urandom);
        ch_b = 8'($urandom);
        ch_c = 8'($urandom);
        beep = 1'($urandom);
        mode = 2'($urandom);
        mute = 1'($urandom);
    endtask

    // One full mix with latency, value, pulse-width and hold checks; ends 8 negedges after strobe.
    task automatic run_mix(input string name, input logic [1:0] m, input int ca, input int cb,
                           input int cc, input logic bp, input logic mt);
        int el, er, k;
        el = mt ? 0 : ref_side(m, ca, cb, cc, bp, 1'b0);
        er = mt ? 0 : ref_side(m, ca, cb, cc, bp, 1'b1);
        set_inputs(m, ca, cb, cc, bp, mt);
        ce = 1'b1;
        @(negedge clk);
        ce = 1'b0;
        scramble_inputs();
        k = 1;
        while (!sv && k < 20) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (!sv || k != 7) begin
            errors++;
            $display("FAIL %s latency: valid=%0b after %0d cycles, want valid=1 after 7", name, sv, k);
        end
        checks++;
        if (audio_l !== 10'(el)) begin
            errors++;
            $display("FAIL %s audio_l: got %0d want %0d", name, audio_l, el);
        end
        checks++;
        if (audio_r !== 10'(er)) begin
            errors++;
            $display("FAIL %s audio_r: got %0d want %0d", name, audio_r, er);
        end
        @(negedge clk);
        checks++;
        if (sv !== 1'b0) begin
            errors++;
            $display("FAIL %s pulse: valid=%0b one cycle later, want 0", name, sv);
        end
        checks++;
        if (audio_l !== 10'(el) || audio_r !== 10'(er)) begin
            errors++;
            $display("FAIL %s hold: got L=%0d R=%0d want L=%0d R=%0d", name, audio_l, audio_r, el, er);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ce    = 1'b0;
        set_inputs(2'b00, 0, 0, 0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (audio_l !== 0 || audio_r !== 0 || sv !== 0 || ovr !== 0 || dac_l !== 0 || dac_r !== 0) begin
            errors++;
            $display("FAIL reset_state: L=%0d R=%0d sv=%0b ovr=%0b dac=%0b%0b want all 0",
                     audio_l, audio_r, sv, ovr, dac_l, dac_r);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (audio_l !== 0 || audio_r !== 0 || sv !== 0 || ovr !== 0) begin
            errors++;
            $display("FAIL post_reset_idle: L=%0d R=%0d sv=%0b ovr=%0b want all 0",
                     audio_l, audio_r, sv, ovr);
        end
    endtask

    task automatic test_directed();
        run_mix("abc_a255",    2'b01, 255, 0,  0,  1'b0, 1'b0);
        run_mix("acb_beep",    2'b10, 10,  20, 30, 1'b1, 1'b0);
        run_mix("mono_beep",   2'b00, 10,  20, 30, 1'b1, 1'b0);
        run_mix("mono11_beep", 2'b11, 10,  20, 30, 1'b1, 1'b0);
        run_mix("mono_max",    2'b00, 255, 255, 255, 1'b1, 1'b0);
        run_mix("mono_mute",   2'b00, 255, 255, 255, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            run_mix("random", 2'($urandom), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 255)), 1'($urandom), ($urandom_range(0, 7) == 0));
        end
        checks++;
        if (ovr !== 1'b0) begin
            errors++;
            $display("FAIL random_no_overrun: ovr=%0b want 0", ovr);
        end
    endtask

    // Second strobe exactly 7 clocks after the first is the fastest legal rate.
    task automatic test_back_to_back();
        int e1, e2, k;
        e1 = ref_side(2'b01, 100, 50, 7, 1'b0, 1'b0);
        e2 = ref_side(2'b10, 3, 200, 90, 1'b1, 1'b1);
        set_inputs(2'b01, 100, 50, 7, 1'b0, 1'b0);
        ce = 1'b1;
        @(negedge clk);
        ce = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (sv !== 1'b1 || audio_l !== 10'(e1)) begin
            errors++;
            $display("FAIL b2b_first: sv=%0b L=%0d want sv=1 L=%0d", sv, audio_l, e1);
        end
        set_inputs(2'b10, 3, 200, 90, 1'b1, 1'b0);
        ce = 1'b1;
        @(negedge clk);
        ce = 1'b0;
        k = 1;
        while (!sv && k < 20) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (!sv || k != 7 || audio_r !== 10'(e2)) begin
            errors++;
            $display("FAIL b2b_second: sv=%0b cycles=%0d R=%0d want sv=1 cycles=7 R=%0d", sv, k, audio_r, e2);
        end
        checks++;
        if (ovr !== 1'b0) begin
            errors++;
            $display("FAIL b2b_overrun: ovr=%0b want 0", ovr);
        end
        @(negedge clk);
    endtask

    task automatic test_overrun();
        int el, er, nvalid, gl, gr;
        el = ref_side(2'b01, 40, 60, 80, 1'b1, 1'b0);
        er = ref_side(2'b01, 40, 60, 80, 1'b1, 1'b1);
        gl = -1;
        gr = -1;
        set_inputs(2'b01, 40, 60, 80, 1'b1, 1'b0);
        ce = 1'b1;
        @(negedge clk);
        ce = 1'b0;
        repeat (2) @(negedge clk);
        set_inputs(2'b00, 1, 2, 3, 1'b0, 1'b1);
        ce = 1'b1;
        @(negedge clk);
        ce = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sv) begin
                nvalid++;
                gl = audio_l;
                gr = audio_r;
            end
        end
        checks++;
        if (nvalid != 1) begin
            errors++;
            $display("FAIL overrun_valid_count: got %0d pulses want 1", nvalid);
        end
        checks++;
        if (gl != el || gr != er) begin
            errors++;
            $display("FAIL overrun_result: got L=%0d R=%0d want L=%0d R=%0d", gl, gr, el, er);
        end
        checks++;
        if (ovr !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: ovr=%0b want 1", ovr);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (ovr !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky: ovr=%0b want 1", ovr);
        end
    endtask

    task automatic test_mid_reset();
        int nvalid;
        set_inputs(2'b00, 200, 200, 200, 1'b1, 1'b0);
        ce = 1'b1;
        @(negedge clk);
        ce = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (audio_l !== 0 || audio_r !== 0 || sv !== 0 || ovr !== 0 || dac_l !== 0 || dac_r !== 0) begin
            errors++;
            $display("FAIL midmix_reset: L=%0d R=%0d sv=%0b ovr=%0b dac=%0b%0b want all 0",
                     audio_l, audio_r, sv, ovr, dac_l, dac_r);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nvalid = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (sv) nvalid++;
        end
        checks++;
        if (nvalid != 0) begin
            errors++;
            $display("FAIL aborted_mix_valid: got %0d pulses want 0", nvalid);
        end
        run_mix("after_reset", 2'b01, 17, 33, 99, 1'b0, 1'b0);
    endtask

    // Strobe landing in DONE counts as overrun and does not start another mix.
    task automatic test_done_strobe();
        int el, nvalid;
        el = ref_side(2'b10, 5, 6, 7, 1'b0, 1'b0);
        set_inputs(2'b10, 5, 6, 7, 1'b0, 1'b0);
        ce = 1'b1;
        @(negedge clk);
        ce = 1'b0;
        repeat (5) @(negedge clk);
        ce = 1'b1;
        @(negedge clk);
        ce = 1'b0;
        checks++;
        if (sv !== 1'b1 || audio_l !== 10'(el)) begin
            errors++;
            $display("FAIL done_strobe_result: sv=%0b L=%0d want sv=1 L=%0d", sv, audio_l, el);
        end
        nvalid = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (sv) nvalid++;
        end
        checks++;
        if (nvalid != 0) begin
            errors++;
            $display("FAIL done_strobe_no_mix: got %0d extra pulses want 0", nvalid);
        end
        checks++;
        if (ovr !== 1'b1) begin
            errors++;
            $display("FAIL done_strobe_overrun: ovr=%0b want 1", ovr);
        end
    endtask

    task automatic test_dac();
        int ones_l, ones_r;
        run_mix("dac_512", 2'b00, 255, 255, 2, 1'b0, 1'b0);
        ones_l = 0;
        ones_r = 0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            if (dac_l) ones_l++;
            if (dac_r) ones_r++;
        end
`ifdef PSG_SIGMA_DELTA_EN
        checks++;
        if (ones_l < 511 || ones_l > 513) begin
            errors++;
            $display("FAIL dac_l_density: got %0d ones want 512 +/-1", ones_l);
        end
        checks++;
        if (ones_r < 511 || ones_r > 513) begin
            errors++;
            $display("FAIL dac_r_density: got %0d ones want 512 +/-1", ones_r);
        end
        run_mix("dac_zero", 2'b00, 0, 0, 0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        ones_l = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (dac_l) ones_l++;
        end
        checks++;
        if (ones_l != 0) begin
            errors++;
            $display("FAIL dac_l_zero: got %0d ones want 0", ones_l);
        end
`else
        checks++;
        if (ones_l != 0 || ones_r != 0) begin
            errors++;
            $display("FAIL dac_disabled: got %0d/%0d ones want 0/0", ones_l, ones_r);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_overrun();
        test_mid_reset();
        test_done_strobe();
        test_dac();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/psg_stereo_mixer.md
PSG_STEREO_MIXER -- requirements
Module: psg_stereo_mixer

Interface
REQ-001 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-002 CLK  in  1  system clock; all state on rising edge.
REQ-003 RESET_N  in  1  asynchronous active-low reset.
REQ-004 CE_SAMPLE  in  1  one-CLK sample strobe; starts one mix.
REQ-005 CHANNEL_A/CHANNEL_B/CHANNEL_C  in  8 each  unsigned PSG channel levels from the TurboSound stage.
REQ-006 BEEPER  in  1  ULA beeper bit.
REQ-007 STEREO_MODE  in  2  00 mono, 01 ABC, 10 ACB, 11 mono.
REQ-008 MUTE  in  1  forces mix result to 0.
REQ-009 AUDIO_L/AUDIO_R  out  10 each  unsigned mixed samples.
REQ-010 SAMPLE_VALID  out  1  one-CLK pulse when AUDIO_L/R update.
REQ-011 OVERRUN  out  1  sticky flag, strobe received while busy.
REQ-012 DAC_L/DAC_R  out  1 each  sigma-delta bitstreams (see Configuration).

Function
REQ-013 FSM states: IDLE, LATCH, ADD0, ADD1, ADD2, ADD3, DONE; one state per CLK after LATCH.
REQ-014 IDLE: CE_SAMPLE=1 -> LATCH; CHANNEL_A/B/C, BEEPER, STEREO_MODE, MUTE snapshot captured on that edge.
REQ-015 LATCH clears both 10-bit accumulators, then enters ADD0; ADDn adds term n of the snapshot to each accumulator; ADD3 -> DONE -> IDLE.
REQ-016 Terms (t0,t1,t2,t3) with BP = BEEPER ? 255 : 0. ABC: L=(A,A,B,BP), R=(C,C,B,BP). ACB: L=(A,A,C,BP), R=(B,B,C,BP). Mono: L=R=(A,B,C,BP).
REQ-017 Arithmetic: zero-extend to 10 bits, unsigned; max sum 1020, so no saturation or wrap is needed.
REQ-018 In DONE, AUDIO_L/R load the accumulators, or 0 if snapshot MUTE=1; SAMPLE_VALID=1 for that cycle only.
REQ-019 Latency: a strobe sampled at edge n gives SAMPLE_VALID high in the cycle after edge n+6; the minimum strobe period without overrun is 7 CLK.
REQ-020 CE_SAMPLE=1 in any state other than IDLE is ignored for mixing and sets OVERRUN=1; OVERRUN stays set until reset.
REQ-021 CE_SAMPLE=1 in DONE is an overrun; the FSM returns to IDLE and no new mix starts.
REQ-022 Input changes after LATCH do not affect the mix in progress.
REQ-023 AUDIO_L/R hold their value between updates.

Reset
REQ-024 RESET_N=0 at any time, including mid-mix, gives: FSM IDLE; accumulators, snapshot, AUDIO_L/R = 0; SAMPLE_VALID=0, OVERRUN=0, DAC_L/R=0; sigma-delta accumulators = 0.
REQ-025 After reset is released, the first strobe is processed normally; an aborted mix never produces SAMPLE_VALID.

Configuration
REQ-026 Macro PSG_SIGMA_DELTA_EN.
- Defined: each side has a first-order sigma-delta modulator updated every CLK. It uses an 11-bit accumulator: acc <= acc[9:0] + AUDIO_x. DAC_x = registered acc[10] carry. Ones-density = AUDIO_x/1024.
- Undefined: no modulator logic is built and DAC_L/DAC_R are constant 0.

Structure
REQ-027 Shared package psg_mix_pkg holds:
- FSM state enum;
- STEREO_MODE constants (MODE_MONO, MODE_ABC, MODE_ACB);
- MIX_W=10;
- BEEP_LEVEL=8'd255.
REQ-028 Sub-module psg_sigma_delta (one 10-bit input, one bit out) is instantiated twice under PSG_SIGMA_DELTA_EN.

Verification
REQ-029 ABC, A=255, B=0, C=0, BEEPER=0, strobe -> 7th cycle SAMPLE_VALID, L=510, R=0.
REQ-030 ACB, A=10, B=20, C=30, BEEPER=1 -> L=305, R=325; mono with same inputs -> L=R=315.
REQ-031 Mono, A=B=C=255, BEEPER=1 -> L=R=1020 (no wrap); same inputs with MUTE=1 -> L=R=0 with SAMPLE_VALID pulse.
REQ-032 Strobe, then second strobe 3 CLK later -> one SAMPLE_VALID only, OVERRUN=1 and held; inputs changed after LATCH do not alter the result.
REQ-033 RESET_N low during ADD1 -> all outputs 0, no SAMPLE_VALID; the next strobe yields the correct result.
REQ-034 PSG_SIGMA_DELTA_EN defined, AUDIO_L=512 held -> DAC_L ones-count 512 ±1 over 1024 CLK; AUDIO_L=0 -> DAC_L stuck 0; macro undefined -> DAC_L/R always 0.
